// File: rtl/cmd_dispatcher.sv
// Command dispatcher: buffers commands in an in-order FIFO and dispatches them to the
// NTT and DMA executors, enforcing slot hazards and SYNC barriers and flagging unknown opcodes.
module cmd_dispatcher #(
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [7:0]           cmd_opcode,
  input  logic [3:0]           cmd_slot,
  input  logic [47:0]          cmd_dma_addr,
  output logic                 cmd_ready,
  output logic                 ntt_valid,
  output logic [7:0]           ntt_opcode,
  output logic [3:0]           ntt_slot,
  input  logic                 ntt_ready,
  input  logic                 ntt_done,
  output logic                 dma_valid,
  output logic                 dma_write,
  output logic [3:0]           dma_slot,
  output logic [47:0]          dma_addr,
  input  logic                 dma_ready,
  input  logic                 dma_done,
  output logic [DEPTH_LOG:0]   fifo_level,
  output logic                 idle,
  output logic                 err_unknown,
  output logic [7:0]           err_opcode
);

  typedef enum logic [1:0] {EX_IDLE, EX_ISSUE, EX_BUSY} ex_state_t;

  localparam logic [7:0] OP_LOAD    = 8'h01;
  localparam logic [7:0] OP_STORE   = 8'h02;
  localparam logic [7:0] OP_NTT_FWD = 8'h10;
  localparam logic [7:0] OP_NTT_INV = 8'h11;
  localparam logic [7:0] OP_SYNC    = 8'h20;

  localparam logic [DEPTH_LOG:0]   LEVEL_FULL = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0]   LEVEL_ONE  = (DEPTH_LOG+1)'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE    = DEPTH_LOG'(1);

  logic [7:0]           op_mem   [DEPTH];
  logic [3:0]           slot_mem [DEPTH];
  logic [47:0]          addr_mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG:0]   level;

  logic       push, pop;
  logic       ntt_go, dma_go, sync_go, unk_go;
  logic [7:0] head_op;
  logic [3:0] head_slot;
  logic [47:0] head_addr;
  logic       ntt_idle, dma_idle, ntt_holds_slot, dma_holds_slot;

  ex_state_t ntt_state, ntt_next, dma_state, dma_next;

  assign cmd_ready  = (level != LEVEL_FULL);
  assign push       = cmd_valid && cmd_ready;
  assign fifo_level = level;
  assign head_op    = op_mem[rd_ptr];
  assign head_slot  = slot_mem[rd_ptr];
  assign head_addr  = addr_mem[rd_ptr];

  assign ntt_idle  = (ntt_state == EX_IDLE);
  assign dma_idle  = (dma_state == EX_IDLE);
  assign ntt_valid = (ntt_state == EX_ISSUE);
  assign dma_valid = (dma_state == EX_ISSUE);

  // A slot is owned by an executor from dispatch until its done pulse.
  assign ntt_holds_slot = !ntt_idle && (ntt_slot == head_slot);
  assign dma_holds_slot = !dma_idle && (dma_slot == head_slot);

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= cmd_opcode;
      slot_mem[wr_ptr] <= cmd_slot;
      addr_mem[wr_ptr] <= cmd_dma_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      level <= level + LEVEL_ONE;
      else if (pop && !push) level <= level - LEVEL_ONE;
    end
  end

  // Head-of-line decision: only the oldest command may leave, at most one per cycle.
  always_comb begin
    ntt_go  = 1'b0;
    dma_go  = 1'b0;
    sync_go = 1'b0;
    unk_go  = 1'b0;
    if (level != '0) begin
      case (head_op)
        OP_LOAD, OP_STORE:      dma_go  = dma_idle && !ntt_holds_slot;
        OP_NTT_FWD, OP_NTT_INV: ntt_go  = ntt_idle && !dma_holds_slot;
        OP_SYNC:                sync_go = ntt_idle && dma_idle;
        default:                unk_go  = 1'b1;
      endcase
    end
    pop = ntt_go || dma_go || sync_go || unk_go;
  end

  always_comb begin
    ntt_next = ntt_state;
    case (ntt_state)
      EX_IDLE:  if (ntt_go)    ntt_next = EX_ISSUE;
      EX_ISSUE: if (ntt_ready) ntt_next = EX_BUSY;
      EX_BUSY:  if (ntt_done)  ntt_next = EX_IDLE;
      default:                 ntt_next = EX_IDLE;
    endcase
  end

  always_comb begin
    dma_next = dma_state;
    case (dma_state)
      EX_IDLE:  if (dma_go)    dma_next = EX_ISSUE;
      EX_ISSUE: if (dma_ready) dma_next = EX_BUSY;
      EX_BUSY:  if (dma_done)  dma_next = EX_IDLE;
      default:                 dma_next = EX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ntt_state  <= EX_IDLE;
      dma_state  <= EX_IDLE;
      ntt_opcode <= '0;
      ntt_slot   <= '0;
      dma_write  <= 1'b0;
      dma_slot   <= '0;
      dma_addr   <= '0;
    end else begin
      ntt_state <= ntt_next;
      dma_state <= dma_next;
      if (ntt_go) begin
        ntt_opcode <= head_op;
        ntt_slot   <= head_slot;
      end
      if (dma_go) begin
        dma_write <= (head_op == OP_STORE);
        dma_slot  <= head_slot;
        dma_addr  <= head_addr;
      end
    end
  end

  // idle lags its condition by one cycle; the error capture keeps only the first unknown opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle        <= 1'b1;
      err_unknown <= 1'b0;
      err_opcode  <= '0;
    end else begin
      idle <= (level == '0) && ntt_idle && dma_idle;
      if (unk_go && !err_unknown) begin
        err_unknown <= 1'b1;
        err_opcode  <= head_op;
      end
    end
  end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Self-checking bench for cmd_dispatcher: a queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_cmd_dispatcher;

  localparam int DEPTH     = 4;
  localparam int DEPTH_LOG = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [3:0]  cmd_slot;
  logic [47:0] cmd_dma_addr;
  logic        cmd_ready;
  logic        ntt_valid;
  logic [7:0]  ntt_opcode;
  logic [3:0]  ntt_slot;
  logic        ntt_ready;
  logic        ntt_done;
  logic        dma_valid;
  logic        dma_write;
  logic [3:0]  dma_slot;
  logic [47:0] dma_addr;
  logic        dma_ready;
  logic        dma_done;
  logic [DEPTH_LOG:0] fifo_level;
  logic        idle;
  logic        err_unknown;
  logic [7:0]  err_opcode;

  int checks = 0;
  int errors = 0;
  bit compare_en = 1'b0;

  cmd_dispatcher #(.DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode), .cmd_slot(cmd_slot),
    .cmd_dma_addr(cmd_dma_addr), .cmd_ready(cmd_ready),
    .ntt_valid(ntt_valid), .ntt_opcode(ntt_opcode), .ntt_slot(ntt_slot),
    .ntt_ready(ntt_ready), .ntt_done(ntt_done),
    .dma_valid(dma_valid), .dma_write(dma_write), .dma_slot(dma_slot),
    .dma_addr(dma_addr), .dma_ready(dma_ready), .dma_done(dma_done),
    .fifo_level(fifo_level), .idle(idle),
    .err_unknown(err_unknown), .err_opcode(err_opcode)
  );

  always #5 clk = ~clk;

  // Reference model: a command queue plus, per executor, "requesting" and "running" flags.
  typedef struct {
    logic [7:0]  op;
    logic [3:0]  slot;
    logic [47:0] addr;
  } cmd_t;

  cmd_t        model_q[$];
  bit          m_nreq = 0, m_nrun = 0, m_dreq = 0, m_drun = 0;
  logic [7:0]  m_nop = '0;
  logic [3:0]  m_nslot = '0, m_dslot = '0;
  bit          m_dwrite = 0;
  logic [47:0] m_daddr = '0;
  bit          m_idle = 1, m_err = 0;
  logic [7:0]  m_errop = '0;

  always @(posedge clk or negedge rst_n) begin
    cmd_t h;
    bit   n_busy, d_busy, go_n, go_d, go_s, go_u, can_push;
    if (!rst_n) begin
      model_q.delete();
      m_nreq = 0; m_nrun = 0; m_dreq = 0; m_drun = 0;
      m_nop = '0; m_nslot = '0; m_dslot = '0; m_dwrite = 0; m_daddr = '0;
      m_idle = 1; m_err = 0; m_errop = '0;
    end else begin
      n_busy   = m_nreq || m_nrun;
      d_busy   = m_dreq || m_drun;
      can_push = cmd_valid && (model_q.size() != DEPTH);
      go_n = 0; go_d = 0; go_s = 0; go_u = 0;
      m_idle = (model_q.size() == 0) && !n_busy && !d_busy;
      if (model_q.size() > 0) begin
        h = model_q[0];
        if (h.op == 8'h01 || h.op == 8'h02)      go_d = !d_busy && !(n_busy && m_nslot == h.slot);
        else if (h.op == 8'h10 || h.op == 8'h11) go_n = !n_busy && !(d_busy && m_dslot == h.slot);
        else if (h.op == 8'h20)                  go_s = !n_busy && !d_busy;
        else                                     go_u = 1;
      end
      if (m_nreq && ntt_ready) begin m_nreq = 0; m_nrun = 1; end
      else if (m_nrun && ntt_done) m_nrun = 0;
      if (m_dreq && dma_ready) begin m_dreq = 0; m_drun = 1; end
      else if (m_drun && dma_done) m_drun = 0;
      if (go_n) begin m_nreq = 1; m_nop = h.op; m_nslot = h.slot; end
      if (go_d) begin m_dreq = 1; m_dwrite = (h.op == 8'h02); m_dslot = h.slot; m_daddr = h.addr; end
      if (go_u && !m_err) begin m_err = 1; m_errop = h.op; end
      if (go_n || go_d || go_s || go_u) void'(model_q.pop_front());
      if (can_push) model_q.push_back('{cmd_opcode, cmd_slot, cmd_dma_addr});
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("m.cmd_ready",   64'(cmd_ready),   64'(model_q.size() != DEPTH));
      checkOutput("m.fifo_level",  64'(fifo_level),  64'(model_q.size()));
      checkOutput("m.ntt_valid",   64'(ntt_valid),   64'(m_nreq));
      checkOutput("m.ntt_opcode",  64'(ntt_opcode),  64'(m_nop));
      checkOutput("m.ntt_slot",    64'(ntt_slot),    64'(m_nslot));
      checkOutput("m.dma_valid",   64'(dma_valid),   64'(m_dreq));
      checkOutput("m.dma_write",   64'(dma_write),   64'(m_dwrite));
      checkOutput("m.dma_slot",    64'(dma_slot),    64'(m_dslot));
      checkOutput("m.dma_addr",    64'(dma_addr),    64'(m_daddr));
      checkOutput("m.idle",        64'(idle),        64'(m_idle));
      checkOutput("m.err_unknown", 64'(err_unknown), 64'(m_err));
      checkOutput("m.err_opcode",  64'(err_opcode),  64'(m_errop));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] op, input logic [3:0] slot,
                               input logic [47:0] addr);
    cmd_valid    = v;
    cmd_opcode   = op;
    cmd_slot     = slot;
    cmd_dma_addr = addr;
  endtask

  task automatic pushCmd(input logic [7:0] op, input logic [3:0] slot, input logic [47:0] addr);
    applyStimulus(1'b1, op, slot, addr);
    tick();
    applyStimulus(1'b0, 8'h00, 4'h0, 48'h0);
  endtask

  task automatic pulseNtt();
    ntt_done = 1'b1; tick(); ntt_done = 1'b0;
  endtask

  task automatic pulseDma();
    dma_done = 1'b1; tick(); dma_done = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (!(idle === 1'b1 && fifo_level == '0) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("idle_reached", 64'(idle), 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 4'h0, 48'h0);
    ntt_ready = 1'b0; ntt_done = 1'b0; dma_ready = 1'b0; dma_done = 1'b0;
    repeat (2) tick();
    checkOutput("rst.cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst.idle", 64'(idle), 64'd1);
    checkOutput("rst.fifo_level", 64'(fifo_level), 64'd0);
    checkOutput("rst.ntt_valid", 64'(ntt_valid), 64'd0);
    checkOutput("rst.dma_valid", 64'(dma_valid), 64'd0);
    rst_n = 1'b1;
    compare_en = 1'b1;
    tick();

    $display("[TB] single NTT");
    ntt_ready = 1'b1;
    pushCmd(8'h10, 4'd3, 48'h0);
    tick();
    checkOutput("s1.ntt_valid_on", 64'(ntt_valid), 64'd1);
    checkOutput("s1.ntt_slot", 64'(ntt_slot), 64'd3);
    checkOutput("s1.ntt_opcode", 64'(ntt_opcode), 64'h10);
    checkOutput("s1.idle_busy", 64'(idle), 64'd0);
    tick();
    checkOutput("s1.ntt_valid_off", 64'(ntt_valid), 64'd0);
    repeat (3) tick();
    pulseNtt();
    checkOutput("s1.idle_lag", 64'(idle), 64'd0);
    tick();
    checkOutput("s1.idle_back", 64'(idle), 64'd1);

    $display("[TB] back-pressure");
    ntt_ready = 1'b0;
    for (int i = 1; i <= 5; i++) pushCmd(8'h10, 4'(i), 48'h0);
    checkOutput("s2.level_full", 64'(fifo_level), 64'd4);
    checkOutput("s2.cmd_ready_low", 64'(cmd_ready), 64'd0);
    checkOutput("s2.ntt_slot_head", 64'(ntt_slot), 64'd1);
    applyStimulus(1'b1, 8'h10, 4'd6, 48'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("s2.level_held", 64'(fifo_level), 64'd4);
    end
    applyStimulus(1'b0, 8'h00, 4'h0, 48'h0);
    ntt_ready = 1'b1;
    ntt_done  = 1'b1;
    waitIdle(60);
    ntt_done  = 1'b0;

    $display("[TB] slot hazard");
    dma_ready = 1'b1;
    pushCmd(8'h01, 4'd2, 48'h1234_5678_9ABC);
    pushCmd(8'h10, 4'd2, 48'h0);
    checkOutput("s3.dma_valid", 64'(dma_valid), 64'd1);
    checkOutput("s3.dma_write", 64'(dma_write), 64'd0);
    checkOutput("s3.dma_slot", 64'(dma_slot), 64'd2);
    checkOutput("s3.dma_addr", 64'(dma_addr), 64'h1234_5678_9ABC);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("s3.ntt_blocked", 64'(ntt_valid), 64'd0);
      checkOutput("s3.dma_valid_off", 64'(dma_valid), 64'd0);
    end
    pulseDma();
    checkOutput("s3.ntt_still_blocked", 64'(ntt_valid), 64'd0);
    tick();
    checkOutput("s3.ntt_released", 64'(ntt_valid), 64'd1);
    checkOutput("s3.ntt_slot", 64'(ntt_slot), 64'd2);
    tick();
    pulseNtt();
    waitIdle(20);

    pushCmd(8'h02, 4'd2, 48'hABCD_0000_0042);
    pushCmd(8'h11, 4'd5, 48'h0);
    checkOutput("s3b.dma_write", 64'(dma_write), 64'd1);
    tick();
    checkOutput("s3b.ntt_concurrent", 64'(ntt_valid), 64'd1);
    checkOutput("s3b.ntt_slot", 64'(ntt_slot), 64'd5);
    checkOutput("s3b.ntt_opcode", 64'(ntt_opcode), 64'h11);
    tick();
    ntt_done = 1'b1; dma_done = 1'b1;
    tick();
    ntt_done = 1'b0; dma_done = 1'b0;
    waitIdle(20);

    $display("[TB] SYNC barrier");
    pushCmd(8'h01, 4'd1, 48'h0000_0000_1000);
    pushCmd(8'h20, 4'd0, 48'h0);
    pushCmd(8'h10, 4'd4, 48'h0);
    checkOutput("s4.level", 64'(fifo_level), 64'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("s4.ntt_wait", 64'(ntt_valid), 64'd0);
    end
    pulseDma();
    checkOutput("s4.after_done", 64'(ntt_valid), 64'd0);
    tick();
    checkOutput("s4.sync_pop_ntt", 64'(ntt_valid), 64'd0);
    checkOutput("s4.sync_pop_level", 64'(fifo_level), 64'd1);
    tick();
    checkOutput("s4.ntt_issue", 64'(ntt_valid), 64'd1);
    checkOutput("s4.ntt_slot", 64'(ntt_slot), 64'd4);
    tick();
    pulseNtt();
    waitIdle(20);

    $display("[TB] unknown opcodes");
    pushCmd(8'h7E, 4'd0, 48'h0);
    pushCmd(8'h33, 4'd0, 48'h0);
    checkOutput("s5.err_unknown", 64'(err_unknown), 64'd1);
    checkOutput("s5.err_opcode", 64'(err_opcode), 64'h7E);
    tick();
    checkOutput("s5.err_kept", 64'(err_opcode), 64'h7E);
    checkOutput("s5.level", 64'(fifo_level), 64'd0);
    checkOutput("s5.no_ntt", 64'(ntt_valid), 64'd0);
    checkOutput("s5.no_dma", 64'(dma_valid), 64'd0);
    waitIdle(10);

    $display("[TB] async reset mid-flight");
    pushCmd(8'h01, 4'd3, 48'h0000_DEAD_BEEF);
    for (int i = 0; i < 3; i++) pushCmd(8'h10, 4'd3, 48'h0);
    checkOutput("s6.level", 64'(fifo_level), 64'd3);
    checkOutput("s6.idle", 64'(idle), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s6.cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("s6.level_rst", 64'(fifo_level), 64'd0);
    checkOutput("s6.idle_rst", 64'(idle), 64'd1);
    checkOutput("s6.dma_valid", 64'(dma_valid), 64'd0);
    checkOutput("s6.dma_addr", 64'(dma_addr), 64'd0);
    checkOutput("s6.dma_slot", 64'(dma_slot), 64'd0);
    checkOutput("s6.ntt_slot", 64'(ntt_slot), 64'd0);
    checkOutput("s6.err_unknown", 64'(err_unknown), 64'd0);
    checkOutput("s6.err_opcode", 64'(err_opcode), 64'd0);
    tick();
    rst_n = 1'b1;
    pulseDma();
    checkOutput("s6.late_done_dma", 64'(dma_valid), 64'd0);
    checkOutput("s6.late_done_idle", 64'(idle), 64'd1);
    tick();
    checkOutput("s6.final_idle", 64'(idle), 64'd1);
    checkOutput("s6.final_ntt", 64'(ntt_valid), 64'd0);

    compare_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
